// File: rtl/pio_phy_pkg.sv
// Shared definitions for the parallel-port line front end and the PIO block
// downstream of it.
package pio_phy_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_ACK    = 2'd2
   } tPhyState;

   localparam int unsigned CTRL_PHASE = 0;
   localparam int unsigned CTRL_CMD   = 1;
   localparam int unsigned CTRL_LOW   = 2;
   localparam int unsigned CTRL_HIGH  = 3;
   localparam int unsigned CTRL_CLR   = 4;
   localparam int unsigned CTRL_W     = 5;

   localparam int unsigned FILT_LEN_DEF = 4;
   localparam int unsigned FILT_W_DEF   = 3;
   localparam int unsigned ACK_LEN_DEF  = 8;

endpackage

// File: rtl/pio_line_filter.sv
// One control line: two-stage synchroniser followed by a persistence filter
// that flags a glitch whenever a partial excursion collapses back.
module pio_line_filter
   import pio_phy_pkg::*;
#(
   parameter int unsigned FILT_LEN = FILT_LEN_DEF,
   parameter int unsigned FILT_W   = FILT_W_DEF
) (
   input  logic Clk,
   input  logic nReset,
   input  logic iPin,
   output logic oLevel,
   output logic oGlitch
);

   logic              meta_q;
   logic              sync_q;
   logic              level_q, level_d;
   logic [FILT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         meta_q  <= 1'b0;
         sync_q  <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         meta_q  <= iPin;
         sync_q  <= meta_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   // The level flips on the FILT_LEN-th consecutive cycle of disagreement.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      oGlitch = 1'b0;
      if (sync_q == level_q) begin
         oGlitch = (cnt_q != '0);
      end else if (cnt_q == FILT_W'(FILT_LEN - 1)) begin
         level_d = sync_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign oLevel = level_q;

endmodule

// File: rtl/pio_phy.sv
// Parallel-port line front end: conditions host pins for PIO, registers PIO
// data back onto the pins and acknowledges every completed strobe cycle.
module pio_phy
   import pio_phy_pkg::*;
#(
   parameter int unsigned FILT_LEN = FILT_LEN_DEF,
   parameter int unsigned FILT_W   = FILT_W_DEF,
   parameter int unsigned ACK_LEN  = ACK_LEN_DEF
) (
   input  logic              Clk,
   input  logic              nReset,
   input  logic [3:0]        iPinData,
   input  logic [CTRL_W-1:0] iPinCtrl,
   output logic [3:0]        oPData,
   output logic [CTRL_W-1:0] oCtrl,
   input  logic [7:0]        iPDataOut,
   output logic [7:0]        oPinData,
   output logic              oHostAck,
   output logic [7:0]        oGlitchCnt
);

   logic [CTRL_W-1:0] ctrl_w;
   logic [CTRL_W-1:0] glitch_w;
   logic              anyStb;

   logic [3:0] dataMeta_q, dataSync_q, pData_q;
   logic [7:0] pinData_q;
   logic [7:0] glitchCnt_q;
   tPhyState   state_q, state_d;
   logic [7:0] ackCnt_q, ackCnt_d;
   logic       hostAck_q, hostAck_d;

   for (genvar i = 0; i < CTRL_W; i++) begin : g_filt
      pio_line_filter #(
         .FILT_LEN (FILT_LEN),
         .FILT_W   (FILT_W)
      ) u_filt (
         .Clk     (Clk),
         .nReset  (nReset),
         .iPin    (iPinCtrl[i]),
         .oLevel  (ctrl_w[i]),
         .oGlitch (glitch_w[i])
      );
   end

   assign anyStb = ctrl_w[CTRL_CMD] | ctrl_w[CTRL_LOW] | ctrl_w[CTRL_HIGH];

   // Data still loads on the cycle a strobe flips active; the freeze follows.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         dataMeta_q  <= '0;
         dataSync_q  <= '0;
         pData_q     <= '0;
         pinData_q   <= '0;
         glitchCnt_q <= '0;
         state_q     <= S_IDLE;
         ackCnt_q    <= '0;
         hostAck_q   <= 1'b0;
      end else begin
         dataMeta_q <= iPinData;
         dataSync_q <= dataMeta_q;
         if (!anyStb) pData_q <= dataSync_q;
         pinData_q <= iPDataOut;
         if ((|glitch_w) && (glitchCnt_q != '1)) glitchCnt_q <= glitchCnt_q + 8'd1;
         state_q   <= state_d;
         ackCnt_q  <= ackCnt_d;
         hostAck_q <= hostAck_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ackCnt_d  = ackCnt_q;
      hostAck_d = hostAck_q;
      if (ctrl_w[CTRL_CLR]) begin
         state_d   = S_IDLE;
         hostAck_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (anyStb) state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
               if (!anyStb) begin
                  state_d   = S_ACK;
                  ackCnt_d  = 8'(ACK_LEN - 1);
                  hostAck_d = 1'b1;
               end
            end
            S_ACK: begin
               if (ackCnt_q != '0) begin
                  ackCnt_d = ackCnt_q - 8'd1;
               end else begin
                  hostAck_d = 1'b0;
                  state_d   = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign oPData     = pData_q;
   assign oCtrl      = ctrl_w;
   assign oPinData   = pinData_q;
   assign oHostAck   = hostAck_q;
   assign oGlitchCnt = glitchCnt_q;

endmodule

// File: doc/pio_phy.md
Name: pio_phy

Overview:
Parallel-port line front end. It sits directly upstream of the PIO command/data block.
- Conditions raw host-PC pins (nibble data plus five control lines): synchronises, glitch-filters and freezes them.
- Presents clean, stable iPData/iCtrl levels to PIO.
- Registers PIO's 8-bit oPData back onto the pins.
- Generates a host acknowledge pulse after every completed strobe cycle.

Parameters:
FILT_LEN, 4, consecutive cycles a synchronised control bit must differ from its filtered value before the filtered value flips (range 1..7).
FILT_W, 3, width of each filter counter; must hold FILT_LEN.
ACK_LEN, 8, cycles oHostAck stays high after strobe release (1..255).

Ports:
Clk  in  1  system clock
nReset  in  1  reset, asynchronous, active-low
iPinData  in  4  raw host nibble pins, asynchronous
iPinCtrl  in  5  raw host control pins, asynchronous; [0] phase, [1] cmd strobe, [2] low strobe, [3] high strobe, [4] clear
oPData  out  4  clean nibble to PIO iPData
oCtrl  out  5  filtered control levels to PIO iCtrl
iPDataOut  in  8  PIO oPData
oPinData  out  8  registered data to host pins
oHostAck  out  1  acknowledge pin to host, active-high
oGlitchCnt  out  8  saturating count of rejected control glitches

Behaviour:
- Reset (async, nReset=0) clears everything: sync FFs, filters, oPData=0, oCtrl=0, oPinData=0, oHostAck=0, oGlitchCnt=0, FSM=S_IDLE. Reset mid-strobe aborts the sequence with no ack.
- Synchronisation: every iPinData/iPinCtrl bit passes through two FFs. sd/sc = second-stage values.
- Control filter, per bit i, with counter cnt[i]:
  - sc[i]==oCtrl[i]: cnt[i]<=0.
  - Otherwise cnt[i]++. When cnt[i] reaches FILT_LEN-1, oCtrl[i]<=sc[i] and cnt[i]<=0.
  - Clean edge latency from pin = 2 sync + FILT_LEN cycles. FILT_LEN=4 gives 6 cycles.
- Glitch counting:
  - A glitch is sc[i] returning to oCtrl[i] while cnt[i]!=0. oGlitchCnt increments by 1 per cycle in which any bit glitches (several bits in one cycle count once).
  - oGlitchCnt saturates at 8'hFF.
- Data freeze:
  - anyStb = oCtrl[1]|oCtrl[2]|oCtrl[3].
  - When anyStb==0, oPData<=sd every cycle. When anyStb==1, oPData holds.
  - The filter delay (>=1 cycle after sd settles) guarantees oPData is stable before any strobe reaches PIO.
  - On the cycle a strobe filter flips active, oPData still loads; the freeze starts the next cycle. Data therefore matches the value present at activation.
- oCtrl[0] and oCtrl[4] are filtered identically but do not affect the freeze.
- Output path: oPinData<=iPDataOut every cycle (1-cycle latency, no bypass).
- Host handshake FSM (tPhyState):
  - S_IDLE: when anyStb==1, go to S_ACTIVE.
  - S_ACTIVE: when anyStb==0, go to S_ACK, load ackCnt=ACK_LEN-1, and set oHostAck<=1.
  - S_ACK: while ackCnt!=0, ackCnt--. When ackCnt==0, set oHostAck<=0 and go to S_IDLE. oHostAck is high for exactly ACK_LEN cycles.
  - New strobe during S_ACK (anyStb==1): finish the ack first, go to S_IDLE, then S_ACTIVE on the next cycle. The strobe is never lost because anyStb is a level.
  - oCtrl[4] (clear) forces the FSM to S_IDLE and oHostAck<=0 on the next cycle. Filters and data are unaffected.
- Simultaneous strobe edges on different bits are treated as one strobe cycle.

Decomposition:
- Shared package: tPhyState enum (S_IDLE, S_ACTIVE, S_ACK); the iPinCtrl bit indices (CTRL_PHASE=0, CTRL_CMD=1, CTRL_LOW=2, CTRL_HIGH=3, CTRL_CLR=4), also used by PIO; the default FILT_LEN/ACK_LEN constants.
- One natural sub-module, pio_line_filter: one bit with 2-FF sync, counter and glitch flag. It is instantiated five times; the data-nibble sync is inline.

Test Plan:
- Reset: nReset=0 mid-run -> all outputs 0 within the same cycle, FSM S_IDLE, oGlitchCnt=0.
- Clean strobe: iPinData=4'hA, iPinCtrl[2]=1 held 10 cycles -> oCtrl[2]=1 exactly 6 cycles after the pin edge. oPData=4'hA and unchanged when iPinData switches to 4'h5 during the strobe.
- Glitch: iPinCtrl[3] pulsed 2 cycles -> oCtrl[3] stays 0, oGlitchCnt=1. 300 such pulses -> oGlitchCnt=8'hFF.
- Ack: strobe [1] high 10 cycles then low -> oHostAck high exactly 8 cycles, starting 1 cycle after oCtrl[1] falls. A second strobe arriving during the ack -> second 8-cycle ack after return through S_IDLE.
- Output path: iPDataOut=8'hC3 -> oPinData=8'hC3 one cycle later.
- Clear: iPinCtrl[4] asserted during S_ACK -> oHostAck drops 1 cycle after oCtrl[4] rises, FSM S_IDLE.
